// File: rtl/sm4_tau_lin_unit_if.sv
// Word, S-box and result channels of the SM4 tau/linear unit.
// The o_err flag exists only when SM4_TAU_ERR_CHECK_EN is defined.
interface sm4_tau_lin_unit_if;
   logic [31:0] i_word;
   logic        i_mode;
   logic        i_valid;
   logic        o_ready;
   logic [7:0]  o_sbox_data;
   logic        o_sbox_valid;
   logic [7:0]  i_sbox_data;
   logic        i_sbox_valid;
   logic [31:0] o_word;
   logic        o_valid;
   logic        i_ready;
`ifdef SM4_TAU_ERR_CHECK_EN
   logic        o_err;

   modport slave (
      input  i_word, i_mode, i_valid, i_sbox_data, i_sbox_valid, i_ready,
      output o_ready, o_sbox_data, o_sbox_valid, o_word, o_valid, o_err
   );
   modport master (
      output i_word, i_mode, i_valid, i_sbox_data, i_sbox_valid, i_ready,
      input  o_ready, o_sbox_data, o_sbox_valid, o_word, o_valid, o_err
   );
`else
   modport slave (
      input  i_word, i_mode, i_valid, i_sbox_data, i_sbox_valid, i_ready,
      output o_ready, o_sbox_data, o_sbox_valid, o_word, o_valid
   );
   modport master (
      output i_word, i_mode, i_valid, i_sbox_data, i_sbox_valid, i_ready,
      input  o_ready, o_sbox_data, o_sbox_valid, o_word, o_valid
   );
`endif
endinterface

// File: rtl/sm4_tau_lin_unit.sv
// Byte-serial SM4 tau (via external S-box) followed by L or L'.
// Optional sticky protocol-error flag under SM4_TAU_ERR_CHECK_EN.
module sm4_tau_lin_unit #(
   parameter int unsigned SBOX_LAT = 1
) (
   input logic               i_clk,
   input logic               i_rst_n,
   sm4_tau_lin_unit_if.slave bus
);

   if (SBOX_LAT != 1) begin : g_bad_lat
      $error("sm4_tau_lin_unit supports SBOX_LAT == 1 only");
   end

   typedef enum logic [2:0] {StIdle, StIssue, StDrain, StLin, StOut} state_e;

   state_e      state_q, state_d;
   logic [31:0] word_q, word_d;
   logic        mode_q, mode_d;
   logic [1:0]  issue_cnt_q, issue_cnt_d;
   logic [2:0]  rx_cnt_q, rx_cnt_d;
   logic [31:0] b_q, b_d;
   logic [31:0] res_q, res_d;
   logic        in_window;
   logic        capture;

   function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
      return (x << n) | (x >> (32 - n));
   endfunction

   function automatic logic [31:0] lin_l(input logic [31:0] b);
      return b ^ rotl(b, 2) ^ rotl(b, 10) ^ rotl(b, 18) ^ rotl(b, 24);
   endfunction

   function automatic logic [31:0] lin_lp(input logic [31:0] b);
      return b ^ rotl(b, 13) ^ rotl(b, 23);
   endfunction

   // Results are only taken while a word is in flight and at most four per word.
   assign in_window = (state_q == StIssue) || (state_q == StDrain);
   assign capture   = bus.i_sbox_valid && in_window && (rx_cnt_q != 3'd4);

   always_comb begin
      state_d     = state_q;
      word_d      = word_q;
      mode_d      = mode_q;
      issue_cnt_d = issue_cnt_q;
      rx_cnt_d    = rx_cnt_q;
      b_d         = b_q;
      res_d       = res_q;

      if (capture) begin
         b_d      = {b_q[23:0], bus.i_sbox_data};
         rx_cnt_d = rx_cnt_q + 3'd1;
      end

      unique case (state_q)
         StIdle: begin
            if (bus.i_valid) begin
               word_d      = bus.i_word;
               mode_d      = bus.i_mode;
               issue_cnt_d = 2'd0;
               rx_cnt_d    = 3'd0;
               b_d         = 32'd0;
               state_d     = StIssue;
            end
         end
         StIssue: begin
            issue_cnt_d = issue_cnt_q + 2'd1;
            if (issue_cnt_q == 2'd3) state_d = StDrain;
         end
         StDrain: begin
            if (rx_cnt_d == 3'd4) state_d = StLin;
         end
         StLin: begin
            res_d   = mode_q ? lin_lp(b_q) : lin_l(b_q);
            state_d = StOut;
         end
         StOut: begin
            if (bus.i_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q     <= StIdle;
         word_q      <= 32'd0;
         mode_q      <= 1'b0;
         issue_cnt_q <= 2'd0;
         rx_cnt_q    <= 3'd0;
         b_q         <= 32'd0;
         res_q       <= 32'd0;
      end else begin
         state_q     <= state_d;
         word_q      <= word_d;
         mode_q      <= mode_d;
         issue_cnt_q <= issue_cnt_d;
         rx_cnt_q    <= rx_cnt_d;
         b_q         <= b_d;
         res_q       <= res_d;
      end
   end

   always_comb begin
      unique case (issue_cnt_q)
         2'd0: bus.o_sbox_data = word_q[31:24];
         2'd1: bus.o_sbox_data = word_q[23:16];
         2'd2: bus.o_sbox_data = word_q[15:8];
         2'd3: bus.o_sbox_data = word_q[7:0];
      endcase
   end

   assign bus.o_ready      = (state_q == StIdle);
   assign bus.o_sbox_valid = (state_q == StIssue);
   assign bus.o_valid      = (state_q == StOut);
   assign bus.o_word       = res_q;

`ifdef SM4_TAU_ERR_CHECK_EN
   logic err_q, err_d;

   assign err_d = err_q | (bus.i_sbox_valid && !capture);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) err_q <= 1'b0;
      else          err_q <= err_d;
   end

   assign bus.o_err = err_q;
`endif

endmodule

// File: tb/tb_sm4_tau_lin_unit.sv
// Directed bench for sm4_tau_lin_unit with a one-cycle S-box model.
module tb_sm4_tau_lin_unit;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   sm4_tau_lin_unit_if bus ();

   sm4_tau_lin_unit #(.SBOX_LAT(1)) dut (
      .i_clk  (clk),
      .i_rst_n(rst_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   // S-box model: only the entries used by the vectors below.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      case (x)
         8'h00:   return 8'hD6;
         8'h01:   return 8'h90;
         8'h23:   return 8'hF4;
         8'h45:   return 8'h73;
         8'h67:   return 8'hA2;
         default: return 8'h00;
      endcase
   endfunction

   logic       sb_v_q = 1'b0;
   logic [7:0] sb_d_q = 8'h00;
   logic       stray_v = 1'b0;

   always_ff @(posedge clk) begin
      if (!rst_n) sb_v_q <= 1'b0;
      else        sb_v_q <= bus.o_sbox_valid;
      sb_d_q <= sbox(bus.o_sbox_data);
   end

   assign bus.i_sbox_valid = sb_v_q | stray_v;
   assign bus.i_sbox_data  = sb_d_q;

   // Offers a word, waits for accept, then runs until o_valid (or a bound).
   task automatic run_word(input logic [31:0] w, input logic m, input logic hold,
                           input logic [31:0] nxt, output logic [31:0] res,
                           output logic [31:0] issued, output int nreq, output int lat,
                           output bit tmo);
      int n;
      tmo = 0; nreq = 0; issued = 0; lat = 0; res = 0; n = 0;
      @(negedge clk);
      bus.i_word = w; bus.i_mode = m; bus.i_valid = 1'b1;
      while (!bus.o_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!bus.o_ready) begin
         tmo = 1;
         bus.i_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      bus.i_valid = hold; bus.i_word = nxt; bus.i_mode = ~m;
      @(negedge clk);
      while (!bus.o_valid && lat < 40) begin
         if (bus.o_sbox_valid) begin
            issued = {issued[23:0], bus.o_sbox_data};
            nreq++;
         end
         @(negedge clk);
         lat++;
      end
      if (!bus.o_valid) tmo = 1;
      res = bus.o_word;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.i_valid = 1'b1; bus.i_word = 32'h01234567; bus.i_mode = 1'b0; bus.i_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         total++;
         if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0 || bus.o_sbox_valid !== 1'b0 ||
             bus.o_word !== 32'h0) begin
            bad++;
            $display("FAIL reset_state: rdy=%b vld=%b sbv=%b word=%h, required 1 0 0 00000000",
                     bus.o_ready, bus.o_valid, bus.o_sbox_valid, bus.o_word);
         end
      end
      bus.i_valid = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (bus.o_ready !== 1'b1 || bus.o_sbox_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_no_accept: rdy=%b sbv=%b, required 1 0",
                  bus.o_ready, bus.o_sbox_valid);
      end
`ifdef SM4_TAU_ERR_CHECK_EN
      total++;
      if (bus.o_err !== 1'b0) begin
         bad++;
         $display("FAIL reset_err: got %b, required 0", bus.o_err);
      end
`endif
   endtask

   task automatic test_zero_l();
      logic [31:0] res, iss;
      int nreq, lat;
      bit tmo;
      run_word(32'h0, 1'b0, 1'b0, 32'h0, res, iss, nreq, lat, tmo);
      total++;
      if (tmo) begin bad++; $display("FAIL zero_l_timeout: timed out, required o_valid"); end
      total++;
      if (nreq !== 4 || iss !== 32'h0) begin
         bad++;
         $display("FAIL zero_l_issue: %0d reqs bytes %h, required 4 reqs 00000000", nreq, iss);
      end
      total++;
      if (lat !== 6) begin bad++; $display("FAIL zero_l_latency: got %0d, required 6", lat); end
      total++;
      if (res !== 32'h5B5B5B5B) begin
         bad++;
         $display("FAIL zero_l_word: got %h, required 5b5b5b5b", res);
      end
      @(negedge clk);
      total++;
      if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1) begin
         bad++;
         $display("FAIL zero_l_release: vld=%b rdy=%b, required 0 1", bus.o_valid, bus.o_ready);
      end
   endtask

   task automatic test_zero_lp();
      logic [31:0] res, iss;
      int nreq, lat;
      bit tmo;
      run_word(32'h0, 1'b1, 1'b0, 32'h0, res, iss, nreq, lat, tmo);
      total++;
      if (tmo || res !== 32'h67676767) begin
         bad++;
         $display("FAIL zero_lp_word: got %h tmo=%0d, required 67676767", res, tmo);
      end
      @(negedge clk);
   endtask

   task automatic test_pattern();
      logic [31:0] res, iss;
      int nreq, lat;
      bit tmo;
      run_word(32'h01234567, 1'b0, 1'b0, 32'h0, res, iss, nreq, lat, tmo);
      total++;
      if (tmo || nreq !== 4 || iss !== 32'h01234567) begin
         bad++;
         $display("FAIL pattern_issue: %0d reqs bytes %h, required 4 reqs 01234567", nreq, iss);
      end
      total++;
      if (res !== 32'h6EF180C9) begin
         bad++;
         $display("FAIL pattern_l_word: got %h, required 6ef180c9", res);
      end
      @(negedge clk);
      // Mode is flipped by run_word right after accept; the latched mode must win.
      run_word(32'h01234567, 1'b1, 1'b0, 32'h0, res, iss, nreq, lat, tmo);
      total++;
      if (tmo || res !== 32'hCFC85B85) begin
         bad++;
         $display("FAIL pattern_lp_word: got %h tmo=%0d, required cfc85b85", res, tmo);
      end
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      logic [31:0] res, iss;
      int nreq, lat;
      bit tmo;
      bus.i_ready = 1'b0;
      run_word(32'h0, 1'b1, 1'b0, 32'h0, res, iss, nreq, lat, tmo);
      total++;
      if (tmo) begin bad++; $display("FAIL bp_timeout: timed out, required o_valid"); end
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         total++;
         if (bus.o_valid !== 1'b1 || bus.o_word !== 32'h67676767 || bus.o_ready !== 1'b0 ||
             bus.o_sbox_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold: vld=%b word=%h rdy=%b sbv=%b, required 1 67676767 0 0",
                     bus.o_valid, bus.o_word, bus.o_ready, bus.o_sbox_valid);
         end
      end
      bus.i_ready = 1'b1;
      @(negedge clk);
      total++;
      if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1) begin
         bad++;
         $display("FAIL bp_release: vld=%b rdy=%b, required 0 1", bus.o_valid, bus.o_ready);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] res, iss;
      int nreq, lat;
      bit tmo, rose;
      @(negedge clk);
      bus.i_word = 32'h01234567; bus.i_mode = 1'b0; bus.i_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.i_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      total++;
      if (bus.o_sbox_valid !== 1'b1 || bus.o_sbox_data !== 8'h45) begin
         bad++;
         $display("FAIL mid_k2: sbv=%b data=%h, required 1 45", bus.o_sbox_valid,
                  bus.o_sbox_data);
      end
      rst_n = 1'b0;
      @(negedge clk);
      total++;
      if (bus.o_ready !== 1'b1 || bus.o_sbox_valid !== 1'b0 || bus.o_valid !== 1'b0) begin
         bad++;
         $display("FAIL mid_reset_idle: rdy=%b sbv=%b vld=%b, required 1 0 0",
                  bus.o_ready, bus.o_sbox_valid, bus.o_valid);
      end
      rst_n = 1'b1;
      rose = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (bus.o_valid) rose = 1;
      end
      total++;
      if (rose) begin bad++; $display("FAIL mid_no_valid: o_valid rose, required it to stay 0"); end
      run_word(32'h0, 1'b0, 1'b0, 32'h0, res, iss, nreq, lat, tmo);
      total++;
      if (tmo || res !== 32'h5B5B5B5B) begin
         bad++;
         $display("FAIL mid_after_word: got %h tmo=%0d, required 5b5b5b5b", res, tmo);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [31:0] res, iss;
      int nreq, lat;
      bit tmo;
      // i_valid stays high with a different word while the first is in flight.
      run_word(32'h0, 1'b0, 1'b1, 32'h01234567, res, iss, nreq, lat, tmo);
      total++;
      if (tmo || res !== 32'h5B5B5B5B) begin
         bad++;
         $display("FAIL b2b_first: got %h tmo=%0d, required 5b5b5b5b", res, tmo);
      end
      run_word(32'h01234567, 1'b0, 1'b0, 32'h0, res, iss, nreq, lat, tmo);
      total++;
      if (tmo || res !== 32'h6EF180C9 || lat !== 6) begin
         bad++;
         $display("FAIL b2b_second: got %h lat %0d, required 6ef180c9 lat 6", res, lat);
      end
      @(negedge clk);
   endtask

`ifdef SM4_TAU_ERR_CHECK_EN
   task automatic test_err();
      logic [31:0] res, iss;
      int nreq, lat;
      bit tmo;
      @(negedge clk);
      total++;
      if (bus.o_err !== 1'b0) begin bad++; $display("FAIL err_clear: got %b, required 0", bus.o_err); end
      stray_v = 1'b1;
      @(negedge clk);
      stray_v = 1'b0;
      total++;
      if (bus.o_err !== 1'b1) begin bad++; $display("FAIL err_set: got %b, required 1", bus.o_err); end
      run_word(32'h0, 1'b0, 1'b0, 32'h0, res, iss, nreq, lat, tmo);
      total++;
      if (tmo || res !== 32'h5B5B5B5B || bus.o_err !== 1'b1) begin
         bad++;
         $display("FAIL err_sticky: word %h err %b, required 5b5b5b5b 1", res, bus.o_err);
      end
      @(negedge clk);
   endtask
`endif

   initial begin
      bus.i_word = 32'h0; bus.i_mode = 1'b0; bus.i_valid = 1'b0; bus.i_ready = 1'b1;
      test_reset();
      test_zero_l();
      test_zero_lp();
      test_pattern();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
`ifdef SM4_TAU_ERR_CHECK_EN
      test_err();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
